// File: rtl/lut_layer_sched.sv
// One sparse LUT layer on a shared 4-in/2-out table datapath, one neuron per cycle: N_NEURONS cycles after accept.
// Holds out_valid and out_data until out_ready; in_ready stays low from accept until that handshake completes.
module lut_layer_sched #(
    parameter int N_IN      = 16,
    parameter int N_NEURONS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*N_IN-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*N_NEURONS-1:0] out_data,
    input  logic                   cfg_we,
    input  logic                   cfg_sel,
    input  logic [7:0]             cfg_neuron,
    input  logic [31:0]            cfg_data,
    output logic                   cfg_err,
    output logic                   busy
);
    localparam int CW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2*N_IN-1:0] vec;
    logic [7:0]        idx0 [N_NEURONS];
    logic [7:0]        idx1 [N_NEURONS];
    logic [31:0]       tbl  [N_NEURONS];

    logic [1:0] act0;
    logic [1:0] act1;
    logic [3:0] addr;
    logic [1:0] res;
    logic       cfg_ok;

    // Fan-in mux; an index past the last activation matches nothing and reads 2'b00.
    always_comb begin
        act0 = 2'b00;
        act1 = 2'b00;
        for (int i = 0; i < N_IN; i++) begin
            if (idx0[cnt] == 8'(i)) act0 = vec[2*i +: 2];
            if (idx1[cnt] == 8'(i)) act1 = vec[2*i +: 2];
        end
    end

    assign addr      = {act1, act0};
    assign res       = tbl[cnt][{addr, 1'b0} +: 2];
    assign cfg_ok    = (state == IDLE) && ({1'b0, cfg_neuron} < 9'(N_NEURONS));
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            vec      <= '0;
            out_data <= '0;
            cfg_err  <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
                idx0[n] <= '0;
                idx1[n] <= '0;
                tbl[n]  <= '0;
            end
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) begin
                if (cfg_sel) begin
                    tbl[cfg_neuron[CW-1:0]] <= cfg_data;
                end else begin
                    idx0[cfg_neuron[CW-1:0]] <= cfg_data[7:0];
                    idx1[cfg_neuron[CW-1:0]] <= cfg_data[15:8];
                end
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        vec   <= in_data;
                        cnt   <= '0;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    out_data[{cnt, 1'b0} +: 2] <= res;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
